// File: rtl/alu_arb_pkg.sv
// Shared funct3/funct7 encodings and op-legality helper for the ALU arbiter slice.
package alu_arb_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SLL  = 3'd1,
        SLT  = 3'd2,
        SLTU = 3'd3,
        XOR  = 3'd4,
        SRL  = 3'd5,
        OR   = 3'd6,
        AND  = 3'd7
    } funct3_e;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // Only ADD/SRL have an alternate (SUB/SRA) encoding.
    function automatic logic op_legal(logic [2:0] op, logic [6:0] f7);
        return (f7 == F7_BASE) || ((f7 == F7_ALT) && (op == ADD || op == SRL));
    endfunction

endpackage

// File: rtl/arithmetic.sv
// Combinational RV32 integer ALU; result_valid flags a legal funct3/funct7 pair.
module arithmetic
    import alu_arb_pkg::*;
(
    input  logic        valid,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic [2:0]  operation,
    input  logic [6:0]  metadata,
    output logic [31:0] result,
    output logic        result_valid
);

    logic       alt;
    logic [4:0] shamt;

    assign alt   = (metadata == F7_ALT);
    assign shamt = rhs[4:0];

    always_comb begin
        result = '0;
        unique case (operation)
            ADD:     result = alt ? lhs - rhs : lhs + rhs;
            SLL:     result = lhs << shamt;
            SLT:     result = {31'b0, $signed(lhs) < $signed(rhs)};
            SLTU:    result = {31'b0, lhs < rhs};
            XOR:     result = lhs ^ rhs;
            SRL:     result = alt ? $unsigned($signed(lhs) >>> shamt) : lhs >> shamt;
            OR:      result = lhs | rhs;
            AND:     result = lhs & rhs;
            default: result = '0;
        endcase
    end

    assign result_valid = valid & op_legal(operation, metadata);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first valid request at or after ptr wins, one-hot grant plus index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               valid
);

    int unsigned sel;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        sel   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sel = (32'(ptr) + k) % NUM_REQ;
            if (en && !valid && req[sel]) begin
                valid      = 1'b1;
                idx        = ID_W'(sel);
                grant[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with a single registered result slot.
// Define ALU_ARB_ERR_EN to report illegal ops through resp_err instead of dropping them.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][31:0] req_lhs,
    input  logic [NUM_REQ-1:0][31:0] req_rhs,
    input  logic [NUM_REQ-1:0][2:0]  req_operation,
    input  logic [NUM_REQ-1:0][6:0]  req_metadata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_result,
    output logic [ID_W-1:0]          resp_id
`ifdef ALU_ARB_ERR_EN
    ,
    output logic                     resp_err
`endif
);

    typedef enum logic {StEmpty, StFull} slot_e;

    slot_e             state_q;
    logic [ID_W-1:0]   ptr_q;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   gnt_idx;
    logic              issue;
    logic              can_issue;
    logic              slot_write;

    logic [31:0] alu_lhs, alu_rhs, alu_result;
    logic [2:0]  alu_op;
    logic [6:0]  alu_f7;
    logic        alu_ok;

    assign can_issue = (state_q == StEmpty) || resp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .en    (can_issue & ~rst),
        .grant (grant),
        .idx   (gnt_idx),
        .valid (issue)
    );

    assign req_ready = grant;

    // ALU inputs are held at zero outside the granted cycle.
    always_comb begin
        alu_lhs = '0;
        alu_rhs = '0;
        alu_op  = '0;
        alu_f7  = '0;
        if (issue) begin
            alu_lhs = req_lhs[gnt_idx];
            alu_rhs = req_rhs[gnt_idx];
            alu_op  = req_operation[gnt_idx];
            alu_f7  = req_metadata[gnt_idx];
        end
    end

    arithmetic u_alu (
        .valid        (issue),
        .lhs          (alu_lhs),
        .rhs          (alu_rhs),
        .operation    (alu_op),
        .metadata     (alu_f7),
        .result       (alu_result),
        .result_valid (alu_ok)
    );

`ifdef ALU_ARB_ERR_EN
    assign slot_write = issue;
`else
    assign slot_write = issue & alu_ok;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            ptr_q       <= '0;
            resp_result <= '0;
            resp_id     <= '0;
`ifdef ALU_ARB_ERR_EN
            resp_err    <= 1'b0;
`endif
        end else begin
            if (issue) begin
                ptr_q <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (slot_write) begin
                state_q     <= StFull;
                resp_result <= alu_ok ? alu_result : '0;
                resp_id     <= gnt_idx;
`ifdef ALU_ARB_ERR_EN
                resp_err    <= ~alu_ok;
`endif
            end else if (state_q == StFull && resp_ready) begin
                state_q <= StEmpty;
            end
        end
    end

    assign resp_valid = (state_q == StFull);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter (NUM_REQ=2); honours ALU_ARB_ERR_EN.
module tb_alu_arbiter;

    localparam int unsigned N = 2;

    typedef struct packed {
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [2:0]  op;
        logic [6:0]  f7;
    } op_t;

    typedef struct packed {
        logic [31:0] res;
        logic [7:0]  id;
        logic        err;
    } rsp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0][31:0]  req_lhs;
    logic [N-1:0][31:0]  req_rhs;
    logic [N-1:0][2:0]   req_operation;
    logic [N-1:0][6:0]   req_metadata;
    logic                resp_valid;
    logic                resp_ready;
    logic [31:0]         resp_result;
    logic [0:0]          resp_id;
`ifdef ALU_ARB_ERR_EN
    logic                resp_err;
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_lhs       (req_lhs),
        .req_rhs       (req_rhs),
        .req_operation (req_operation),
        .req_metadata  (req_metadata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
`ifdef ALU_ARB_ERR_EN
        .resp_id       (resp_id),
        .resp_err      (resp_err)
`else
        .resp_id       (resp_id)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    op_t  src [N][$];
    rsp_t sb[$];
    rsp_t got[$];
    int   grants[$];
    int   checks   = 0;
    int   failures = 0;
    logic m_full   = 1'b0;
    int   m_ptr    = 0;
    int   got_before;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(logic [31:0] a, logic [31:0] b, logic [2:0] op, logic [6:0] f7);
        op_t o;
        o.lhs = a;
        o.rhs = b;
        o.op  = op;
        o.f7  = f7;
        return o;
    endfunction

    // Reference ALU: RV32 semantics, illegal pairs give err=1 and result 0.
    function automatic rsp_t model(op_t o, int id);
        rsp_t       r;
        logic       ok;
        logic [4:0] sh;
        sh = o.rhs[4:0];
        ok = (o.f7 == 7'h00) || (o.f7 == 7'h20 && (o.op == 3'd0 || o.op == 3'd5));
        case (o.op)
            3'd0: r.res = (o.f7 == 7'h20) ? o.lhs - o.rhs : o.lhs + o.rhs;
            3'd1: r.res = o.lhs << sh;
            3'd2: r.res = ($signed(o.lhs) < $signed(o.rhs)) ? 32'd1 : 32'd0;
            3'd3: r.res = (o.lhs < o.rhs) ? 32'd1 : 32'd0;
            3'd4: r.res = o.lhs ^ o.rhs;
            3'd5: r.res = (o.f7 == 7'h20) ? $unsigned($signed(o.lhs) >>> sh) : o.lhs >> sh;
            3'd6: r.res = o.lhs | o.rhs;
            default: r.res = o.lhs & o.rhs;
        endcase
        if (!ok) r.res = '0;
        r.id  = 8'(id);
        r.err = ~ok;
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src[i].size() > 0) begin
                req_valid[i]     = 1'b1;
                req_lhs[i]       = src[i][0].lhs;
                req_rhs[i]       = src[i][0].rhs;
                req_operation[i] = src[i][0].op;
                req_metadata[i]  = src[i][0].f7;
            end else begin
                req_valid[i]     = 1'b0;
                req_lhs[i]       = '0;
                req_rhs[i]       = '0;
                req_operation[i] = '0;
                req_metadata[i]  = '0;
            end
        end
    endtask

    // One clock: check grant/slot against the model at negedge, then advance both.
    task automatic tick();
        logic [N-1:0] eg;
        logic         can;
        int           idx;
        rsp_t         e, a;
        op_t          o;
        @(negedge clk);
        eg  = '0;
        idx = -1;
        can = !m_full || resp_ready;
        if (can && !rst) begin
            for (int k = 0; k < N; k++) begin
                if (idx < 0 && req_valid[(m_ptr + k) % N]) idx = (m_ptr + k) % N;
            end
        end
        if (idx >= 0) eg[idx] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("resp_valid", 32'(resp_valid), 32'(m_full));
        if (m_full && resp_ready && !rst) begin
            a.res = resp_result;
            a.id  = 8'(resp_id);
`ifdef ALU_ARB_ERR_EN
            a.err = resp_err;
`else
            a.err = 1'b0;
`endif
            got.push_back(a);
            if (sb.size() == 0) begin
                chk("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("resp_result", resp_result, e.res);
                chk("resp_id", 32'(resp_id), 32'(e.id));
`ifdef ALU_ARB_ERR_EN
                chk("resp_err", 32'(resp_err), 32'(e.err));
`endif
            end
        end
        if (rst) begin
            m_full = 1'b0;
            m_ptr  = 0;
            sb.delete();
        end else begin
            if (m_full && resp_ready) m_full = 1'b0;
            if (idx >= 0) begin
                grants.push_back(idx);
                o     = src[idx].pop_front();
                m_ptr = (idx + 1) % N;
                e     = model(o, idx);
                if (!e.err || ERR_EN) begin
                    sb.push_back(e);
                    m_full = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_idle();
        int   n;
        logic busy;
        n    = 0;
        busy = 1'b1;
        while (busy && n < 60) begin
            busy = (src[0].size() != 0) || (src[1].size() != 0) || (sb.size() != 0) || resp_valid;
            if (busy) begin
                tick();
                n++;
            end
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        resp_ready = 1'b1;

        // Reset with both requesters valid; ops are the ADD/SUB pair.
        src[0].push_back(mk(32'h0000_0001, 32'h0000_ffff, 3'd0, 7'h00));
        src[1].push_back(mk(32'h0001_0000, 32'h0000_0001, 3'd0, 7'h20));
        drive();
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_result", resp_result, 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        rst = 1'b0;
        run_idle();
        chk("first_grant", grants[0], 0);
        chk("second_grant", grants[1], 1);
        chk("add_result", got[0].res, 32'h0001_0000);
        chk("add_id", 32'(got[0].id), 32'd0);
        chk("sub_result", got[1].res, 32'h0000_ffff);
        chk("sub_id", 32'(got[1].id), 32'd1);

        // Both valid: strict alternation; then req1 alone every cycle.
        grants.delete();
        src[0].push_back(mk(32'hdead_beef, 32'h0f0f_0f0f, 3'd4, 7'h00));
        src[0].push_back(mk(32'hffff_fffe, 32'h0000_0001, 3'd2, 7'h00));
        src[0].push_back(mk(32'h8000_0001, 32'h0000_0021, 3'd1, 7'h00));
        src[0].push_back(mk(32'hffff_ffff, 32'h0000_0001, 3'd0, 7'h00));
        src[1].push_back(mk(32'hffff_fffe, 32'h0000_0001, 3'd3, 7'h00));
        src[1].push_back(mk(32'h1234_0000, 32'h0000_5678, 3'd6, 7'h00));
        src[1].push_back(mk(32'hf0f0_1234, 32'h0ff0_ffff, 3'd7, 7'h00));
        src[1].push_back(mk(32'h8000_0000, 32'h0000_001f, 3'd5, 7'h00));
        drive();
        run_idle();
        chk("alt_count", grants.size(), 8);
        for (int k = 0; k < 8; k++) chk("alternate", grants[k], k % 2);
        grants.delete();
        for (int k = 0; k < 3; k++) src[1].push_back(mk(32'(k * 7), 32'(k + 3), 3'd0, 7'h00));
        drive();
        run_idle();
        chk("solo_count", grants.size(), 3);
        for (int k = 0; k < 3; k++) chk("solo_req1", grants[k], 1);

        // Stall with SRA result in the slot, then drain+issue in the same cycle.
        resp_ready = 1'b0;
        src[0].push_back(mk(32'ha863_201f, 32'h0000_0004, 3'd5, 7'h20));
        src[1].push_back(mk(32'h0000_0010, 32'h0000_0020, 3'd0, 7'h00));
        drive();
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_result", resp_result, 32'hfa86_3201);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        chk("drain_issue_full", 32'(resp_valid), 32'd1);
        run_idle();

        // Illegal op: consumed, response only with error reporting built in.
        got_before = got.size();
        grants.delete();
        src[0].push_back(mk(32'h0000_0005, 32'h0000_0003, 3'd0, 7'h01));
        drive();
        tick();
        chk("illegal_grant", grants[0], 0);
        run_idle();
`ifdef ALU_ARB_ERR_EN
        chk("illegal_resp_count", got.size(), got_before + 1);
        chk("illegal_err", 32'(got[got.size()-1].err), 32'd1);
        chk("illegal_result", got[got.size()-1].res, 32'd0);
`else
        chk("illegal_no_resp", got.size(), got_before);
`endif

        // Reset while a stalled result sits in the slot with pointer at req1.
        resp_ready = 1'b0;
        src[0].push_back(mk(32'h0000_0005, 32'h0000_0006, 3'd0, 7'h00));
        drive();
        tick();
        src[0].push_back(mk(32'h0000_0011, 32'h0000_0022, 3'd6, 7'h00));
        src[1].push_back(mk(32'h0000_0033, 32'h0000_0044, 3'd4, 7'h00));
        drive();
        tick();
        chk("pre_rst_full", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_empty", 32'(resp_valid), 32'd0);
        grants.delete();
        tick();
        chk("post_rst_grant", grants[0], 0);
        resp_ready = 1'b1;
        run_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
